// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction prefetch queue between program memory and decode
module fetch_prefetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_en,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       instr_valid,
  output logic [XLEN-1:0]            instr_data,
  output logic [XLEN-1:0]            instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] pc_d [DEPTH];
  logic            issue, enq, fire;
  // issue credit counts the in-flight read so a returning response always has a free slot
  always_comb begin
    issue = reset & ~redirect_valid & (({1'b0, count_q} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH));
    enq = reset & ~redirect_valid & inflight_q;
    instr_valid = reset & ~redirect_valid & (count_q != '0);
    fire = instr_valid & instr_ready;
    imem_en = issue;
    imem_addr = fetch_pc_q;
    instr_data = data_q[head_q];
    instr_pc = pc_q[head_q];
    occupancy = count_q;
  end
  // next-state: redirect flushes everything, otherwise enqueue response / dequeue head / issue next read
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    inflight_d = inflight_q;
    data_d = data_q;
    pc_d = pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
      inflight_d = 1'b0;
    end else begin
      if (enq) begin
        data_d[tail_q] = imem_rdata;
        pc_d[tail_q] = inflight_pc_q;
        tail_d = tail_q == PW'(DEPTH-1) ? '0 : tail_q + PW'(1);
      end
      if (fire) head_d = head_q == PW'(DEPTH-1) ? '0 : head_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(fire);
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
    end
  end
  // control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC & ALIGN;
      inflight_pc_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      inflight_q <= inflight_d;
    end
  end
  // queue storage needs no reset: count gates every read of it
  always_ff @(posedge clk) begin
    data_q <= data_d;
    pc_q <= pc_d;
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: random and directed checks of two queue configurations against a queue-based model
module tb_fetch_prefetch_queue;
  localparam logic [31:0] RPC [2] = '{32'h0, 32'hFFFF_FFF8};
  localparam int DEP [2] = '{4, 2};
  logic clk = 1'b0;
  logic reset = 1'b0, redirect_valid = 1'b0, instr_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic en [2];
  logic [31:0] ad [2];
  logic [31:0] rdata [2];
  logic iv [2];
  logic [31:0] idat [2];
  logic [31:0] ipc [2];
  logic [2:0] occ0;
  logic [1:0] occ1;
  int tests = 0, failed = 0;
  logic [31:0] m_fpc [2];
  logic [31:0] m_ipc [2];
  bit m_inf [2];
  logic [63:0] mq [2][$];
  always #5 clk = ~clk;
  fetch_prefetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut0 (
    .clk(clk), .reset(reset), .imem_en(en[0]), .imem_addr(ad[0]), .imem_rdata(rdata[0]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(iv[0]),
    .instr_data(idat[0]), .instr_pc(ipc[0]), .instr_ready(instr_ready), .occupancy(occ0));
  fetch_prefetch_queue #(.XLEN(32), .DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .reset(reset), .imem_en(en[1]), .imem_addr(ad[1]), .imem_rdata(rdata[1]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(iv[1]),
    .instr_data(idat[1]), .instr_pc(ipc[1]), .instr_ready(instr_ready), .occupancy(occ1));
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a >> 2) * 32'h0100_0193 + 32'hC0DE_0000;
  endfunction
  function automatic logic [31:0] occ_of(input int k);
    return k == 0 ? 32'(occ0) : 32'(occ1);
  endfunction
  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s inst%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask
  task automatic step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit m_en, m_valid;
    bit s_en [2];
    logic [31:0] s_ad [2];
    @(negedge clk);
    reset = rst;
    redirect_valid = rv;
    redirect_pc = rpc;
    instr_ready = rdy;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_en = rst && !rv && (mq[k].size() + int'(m_inf[k]) < DEP[k]);
      m_valid = rst && !rv && mq[k].size() != 0;
      chk("imem_en", k, 32'(en[k]), 32'(m_en));
      if (m_en) chk("imem_addr", k, ad[k], m_fpc[k]);
      chk("instr_valid", k, 32'(iv[k]), 32'(m_valid));
      if (m_valid) begin
        chk("instr_pc", k, ipc[k], mq[k][0][63:32]);
        chk("instr_data", k, idat[k], mq[k][0][31:0]);
      end
      if (rst) chk("occupancy", k, occ_of(k), 32'(mq[k].size()));
      s_en[k] = en[k];
      s_ad[k] = ad[k];
      if (!rst) begin
        m_fpc[k] = RPC[k];
        mq[k].delete();
        m_inf[k] = 1'b0;
      end else if (rv) begin
        m_fpc[k] = {rpc[31:2], 2'b00};
        mq[k].delete();
        m_inf[k] = 1'b0;
      end else begin
        if (m_valid && rdy) void'(mq[k].pop_front());
        if (m_inf[k]) mq[k].push_back({m_ipc[k], mem(m_ipc[k])});
        m_inf[k] = m_en;
        if (m_en) begin
          m_ipc[k] = m_fpc[k];
          m_fpc[k] = m_fpc[k] + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) rdata[k] = s_en[k] ? mem(s_ad[k]) : $urandom;
  endtask
  initial begin
    rdata[0] = '0;
    rdata[1] = '0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    step(1, 1, 32'h40, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    chk("stall_full", 0, occ_of(0), 32'd4);
    chk("stall_no_issue", 0, 32'(en[0]), 32'd0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(1, 1, 32'h43, 0);
    chk("redirect_flush", 0, occ_of(0), 32'd0);
    chk("redirect_align", 0, ad[0], 32'h40);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("reset_flush", 0, occ_of(0), 32'd0);
    chk("reset_pc", 1, ad[1], 32'hFFFF_FFF8);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(39) != 0, $urandom_range(11) == 0, $urandom, $urandom_range(2) != 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
